instruction_prefetch_buffer: RTL and testbench
==============================================

# instruction_prefetch_buffer

Parametrised instruction-fetch front end that owns the instruction memory, a fetch program counter and a small prefetch FIFO. It streams word-aligned instructions with their PCs to the decode stage over a valid/ready handshake, accepts branch/jump redirects that flush in-flight entries, and provides a write port for loading the program at run time. It sits between the control unit (redirects) and the decoder, replacing the static, combinational instruction memory.

## Interface
- DATA_WIDTH, 32, instruction and address width
- MEM_DEPTH, 256, instruction memory depth in words
- FIFO_DEPTH, 4, prefetch entries (power of two, ≥2)
- RESET_PC, 0, fetch address after reset (word aligned)

- Clk  input  1  clock, all state updates on rising edge
- Rst_n  input  1  asynchronous active-low reset
- Load_En  input  1  program-load write strobe
- Load_Addr  input  DATA_WIDTH  byte address of word to write
- Load_Data  input  DATA_WIDTH  word to write
- Redirect_En  input  1  flush and restart fetch
- Redirect_Addr  input  DATA_WIDTH  new fetch byte address
- Inst_Ready  input  1  decoder accepts head entry
- Inst_Valid  output  1  head entry present
- Instruction  output  DATA_WIDTH  head instruction
- Inst_PC  output  DATA_WIDTH  byte address of head instruction
- Inst_Fault  output  1  head entry is an out-of-range fetch
- Fifo_Count  output  $clog2(FIFO_DEPTH)+1  occupied entries

## Operation
- Memory word index = address[DATA_WIDTH-1:2]; address bits [1:0] ignored on fetch, load and redirect (Redirect_Addr low bits cleared when stored to PC).
- Memory contents not cleared by reset; loaded only through Load_En.
- Fetch state: FETCH or HALT. Reset → FETCH, PC = RESET_PC, FIFO empty.
- Push condition (FETCH, no Load_En, no Redirect_En, and Fifo_Count < FIFO_DEPTH or a pop this cycle): entry {mem[PC idx], PC, fault=0} pushed, PC += 4.
- Out-of-range: if PC idx ≥ MEM_DEPTH, entry {0, PC, fault=1} pushed instead, PC unchanged, state → HALT. HALT pushes nothing until redirect.
- Pop: Inst_Valid && Inst_Ready removes head.
- Redirect_En: FIFO emptied, PC = aligned Redirect_Addr, state → FETCH; no push and no pop that cycle; overrides Load_En stall effect on fetch but load write still performed.
- Load_En: mem[Load_Addr idx] = Load_Data if idx < MEM_DEPTH, else dropped; fetch push suppressed that cycle (avoids read of word under write). Entries already in the FIFO are not updated.
- PC arithmetic modulo 2^DATA_WIDTH; no wrap inside memory (overflow past MEM_DEPTH faults).

## Timing
- Reset values: Inst_Valid 0, Instruction 0, Inst_PC 0, Inst_Fault 0, Fifo_Count 0; internal PC = RESET_PC, state FETCH.
- Outputs are registered FIFO head; Inst_Valid = (Fifo_Count ≠ 0).
- Latency: first Inst_Valid on the cycle after the first rising edge following Rst_n deassertion; after redirect at edge N, Inst_Valid low for cycle after N, target instruction valid after edge N+1.
- Throughput: one instruction per cycle with Inst_Ready held high and no load/redirect.
- Full: push allowed when full only if a pop occurs the same edge (count stays FIFO_DEPTH).
- Empty with Inst_Ready high: no effect.
- Instruction/Inst_PC stable while Inst_Valid && !Inst_Ready.
- Rst_n assertion mid-stream: FIFO and PC reset immediately, memory retained.

## Test plan
- Load words 0..7 with 0x1000_0000+i, release reset, Inst_Ready=1 → Instruction 0x1000_0000..0x1000_0007 on consecutive cycles, Inst_PC 0,4,…,28, first valid one cycle after reset release.
- Inst_Ready=0 for 10 cycles → Fifo_Count saturates at 4, head stays PC 0; release → PCs 0,4,8,12,16 with no gap or duplicate.
- Redirect_En with Redirect_Addr=0x23 while FIFO holds 3 entries → Fifo_Count 0 next cycle, next delivered Inst_PC 0x20 with mem[8], old entries never seen.
- Redirect to 0x3F8 (MEM_DEPTH=256) → entries PC 0x3F8, 0x3FC normal, then PC 0x400 with Inst_Fault=1, Instruction 0, then no further valid entries until redirect to 0.
- Load_En writing word 5 = 0xDEAD_BEEF during streaming → fetch stalls one cycle that edge; after redirect to 0x14, Instruction 0xDEAD_BEEF; Load_Addr 0x400 leaves memory unchanged.
- Assert Rst_n low mid-stream with full FIFO → Inst_Valid and Fifo_Count 0 immediately (asynchronous), restart from RESET_PC with memory contents intact.

Source files
------------

// File: rtl/instruction_prefetch_buffer.sv
// Instruction fetch front end: run-time loadable instruction memory, fetch PC and prefetch FIFO toward decode.
// Latency: first entry valid one cycle after the first post-reset edge; one cycle of bubble after a redirect.
// Backpressure: Inst_Ready low holds the head entry; fetch stops when the FIFO is full unless a pop frees a slot.
module instruction_prefetch_buffer #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    MEM_DEPTH  = 256,
  parameter int                    FIFO_DEPTH = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                          Clk,
  input  logic                          Rst_n,
  input  logic                          Load_En,
  input  logic [DATA_WIDTH-1:0]         Load_Addr,
  input  logic [DATA_WIDTH-1:0]         Load_Data,
  input  logic                          Redirect_En,
  input  logic [DATA_WIDTH-1:0]         Redirect_Addr,
  input  logic                          Inst_Ready,
  output logic                          Inst_Valid,
  output logic [DATA_WIDTH-1:0]         Instruction,
  output logic [DATA_WIDTH-1:0]         Inst_PC,
  output logic                          Inst_Fault,
  output logic [$clog2(FIFO_DEPTH):0]   Fifo_Count
);

  // Word index width into the instruction memory (at least one bit).
  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  // FIFO pointer width; FIFO_DEPTH is a power of two so pointers wrap naturally.
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  // Fetch state encoding.
  localparam logic [0:0] ST_FETCH = 1'b0;
  localparam logic [0:0] ST_HALT  = 1'b1;

  // Instruction storage; deliberately not reset so a loaded program survives reset.
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Prefetch FIFO storage and bookkeeping.
  logic [DATA_WIDTH-1:0] fifo_inst  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_pc    [FIFO_DEPTH];
  logic                  fifo_fault [FIFO_DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [CW-1:0]         count;

  // Fetch engine state.
  logic [DATA_WIDTH-1:0] pc;
  logic [0:0]            state;

  // Datapath / control nets.
  logic [DATA_WIDTH-1:0] pc_idx_ext;
  logic [DATA_WIDTH-1:0] load_idx_ext;
  logic                  pc_oob;
  logic                  load_ok;
  logic                  fifo_full;
  logic                  pop;
  logic                  push;
  logic [DATA_WIDTH-1:0] mem_rd;
  logic [DATA_WIDTH-1:0] push_inst;
  logic [DATA_WIDTH-1:0] redirect_pc;

  // Byte-offset bits are architecturally ignored on load and redirect.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{Load_Addr[1:0], Redirect_Addr[1:0]};

  // Word indices are compared at full width so addresses beyond the memory fault
  // instead of aliasing back into it.
  assign pc_idx_ext   = {2'b00, pc[DATA_WIDTH-1:2]};
  assign load_idx_ext = {2'b00, Load_Addr[DATA_WIDTH-1:2]};
  assign pc_oob       = (pc_idx_ext >= DATA_WIDTH'(MEM_DEPTH));
  assign load_ok      = (load_idx_ext < DATA_WIDTH'(MEM_DEPTH));
  assign redirect_pc  = {Redirect_Addr[DATA_WIDTH-1:2], 2'b00};

  assign fifo_full = (count == CW'(FIFO_DEPTH));

  // A redirect flushes the FIFO, so nothing is handed to decode on that edge.
  assign pop = (count != '0) && Inst_Ready && !Redirect_En;

  // Fetch only when running, not loading (avoids reading a word under write),
  // not redirecting, and there is room now or a slot frees up on this edge.
  assign push = (state == ST_FETCH) && !Load_En && !Redirect_En && (!fifo_full || pop);

  // Memory read is only meaningful when the PC is in range; faulting entries carry zero.
  assign mem_rd    = mem[pc[AW+1:2]];
  assign push_inst = pc_oob ? '0 : mem_rd;

  // Program load port; out-of-range writes are silently dropped, and loads are
  // honoured even while redirecting or in reset.
  always_ff @(posedge Clk) begin
    if (Load_En && load_ok) begin
      mem[Load_Addr[AW+1:2]] <= Load_Data;
    end
  end

  // FIFO payload storage; cleared on reset so the outputs read zero after reset.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_inst[i]  <= '0;
        fifo_pc[i]    <= '0;
        fifo_fault[i] <= 1'b0;
      end
    end else if (push) begin
      fifo_inst[wr_ptr]  <= push_inst;
      fifo_pc[wr_ptr]    <= pc;
      fifo_fault[wr_ptr] <= pc_oob;
    end
  end

  // FIFO pointers and occupancy; a redirect empties the FIFO outright.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (Redirect_En) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Fetch PC and FETCH/HALT state: advance on a normal push, freeze and halt on
  // an out-of-range fetch, restart at the aligned target on redirect.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      pc    <= RESET_PC;
      state <= ST_FETCH;
    end else if (Redirect_En) begin
      pc    <= redirect_pc;
      state <= ST_FETCH;
    end else if (push) begin
      if (pc_oob) begin
        state <= ST_HALT;
      end else begin
        pc <= pc + DATA_WIDTH'(4);
      end
    end
  end

  // Head of the FIFO is presented directly from registered storage.
  assign Inst_Valid  = (count != '0);
  assign Instruction = fifo_inst[rd_ptr];
  assign Inst_PC     = fifo_pc[rd_ptr];
  assign Inst_Fault  = fifo_fault[rd_ptr];
  assign Fifo_Count  = count;

endmodule

// File: tb/tb_instruction_prefetch_buffer.sv
// Randomised bench for instruction_prefetch_buffer against a queue-based reference model.
// Each cycle: drive inputs after the falling edge, advance the model at the rising edge,
// compare all outputs at the next falling edge.
module tb_instruction_prefetch_buffer;

  localparam int DW    = 32;
  localparam int MDEP  = 256;
  localparam int FDEP  = 4;

  logic          Clk;
  logic          Rst_n;
  logic          Load_En;
  logic [DW-1:0] Load_Addr;
  logic [DW-1:0] Load_Data;
  logic          Redirect_En;
  logic [DW-1:0] Redirect_Addr;
  logic          Inst_Ready;
  logic          Inst_Valid;
  logic [DW-1:0] Instruction;
  logic [DW-1:0] Inst_PC;
  logic          Inst_Fault;
  logic [2:0]    Fifo_Count;

  instruction_prefetch_buffer #(
    .DATA_WIDTH (DW),
    .MEM_DEPTH  (MDEP),
    .FIFO_DEPTH (FDEP),
    .RESET_PC   (32'h0)
  ) dut (
    .Clk           (Clk),
    .Rst_n         (Rst_n),
    .Load_En       (Load_En),
    .Load_Addr     (Load_Addr),
    .Load_Data     (Load_Data),
    .Redirect_En   (Redirect_En),
    .Redirect_Addr (Redirect_Addr),
    .Inst_Ready    (Inst_Ready),
    .Inst_Valid    (Inst_Valid),
    .Instruction   (Instruction),
    .Inst_PC       (Inst_PC),
    .Inst_Fault    (Inst_Fault),
    .Fifo_Count    (Fifo_Count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model: a queue of delivered-in-order entries plus fetch PC and halt flag.
  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fault;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_mem [MDEP];
  logic [31:0] m_pc;
  bit          m_halt;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pc   = 32'h0;
    m_halt = 0;
  endtask

  // One clock edge of architectural behaviour, taken straight from the fetch rules.
  task automatic model_step(input logic ld, input logic [31:0] la, input logic [31:0] ldd,
                            input logic rd, input logic [31:0] ra, input logic rdy);
    ent_t        e;
    bit          do_pop;
    bit          do_push;
    logic [31:0] idx;
    if (rd) begin
      q.delete();
      m_pc   = {ra[31:2], 2'b00};
      m_halt = 0;
    end else begin
      do_pop  = (q.size() != 0) && rdy;
      do_push = !m_halt && !ld && ((q.size() < FDEP) || do_pop);
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        idx = m_pc >> 2;
        e.pc = m_pc;
        if (idx >= MDEP) begin
          e.inst  = 32'h0;
          e.fault = 1'b1;
          m_halt  = 1;
        end else begin
          e.inst  = m_mem[idx];
          e.fault = 1'b0;
          m_pc    = m_pc + 32'd4;
        end
        q.push_back(e);
      end
    end
    if (ld && ((la >> 2) < MDEP)) m_mem[la >> 2] = ldd;
  endtask

  task automatic compare_outputs();
    check("valid", Inst_Valid, (q.size() != 0));
    check("count", Fifo_Count, q.size());
    if (q.size() != 0) begin
      check("instruction", Instruction, q[0].inst);
      check("inst_pc", Inst_PC, q[0].pc);
      check("inst_fault", Inst_Fault, q[0].fault);
    end
  endtask

  // Called just after a falling edge: drive, advance one rising edge, compare.
  task automatic cycle(input logic ld, input logic [31:0] la, input logic [31:0] ldd,
                       input logic rd, input logic [31:0] ra, input logic rdy);
    Load_En       = ld;
    Load_Addr     = la;
    Load_Data     = ldd;
    Redirect_En   = rd;
    Redirect_Addr = ra;
    Inst_Ready    = rdy;
    @(posedge Clk);
    model_step(ld, la, ldd, rd, ra, rdy);
    @(negedge Clk);
    compare_outputs();
  endtask

  task automatic stream(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, rdy);
  endtask

  logic [31:0] rnd_ra;
  logic [31:0] rnd_la;
  bit          seen_fault;

  initial begin
    Rst_n = 1'b0;
    Load_En = 1'b0; Load_Addr = '0; Load_Data = '0;
    Redirect_En = 1'b0; Redirect_Addr = '0; Inst_Ready = 1'b0;
    model_reset();
    @(negedge Clk);

    // Load the whole program while held in reset; reset outputs must stay zero.
    for (int i = 0; i < MDEP; i++) begin
      Load_En   = 1'b1;
      Load_Addr = i * 4;
      Load_Data = (i < 8) ? (32'h1000_0000 + i) : $urandom;
      m_mem[i]  = Load_Data;
      @(posedge Clk);
      @(negedge Clk);
      if (i % 64 == 0) begin
        check("rst_valid", Inst_Valid, 1'b0);
        check("rst_instruction", Instruction, 32'h0);
        check("rst_pc", Inst_PC, 32'h0);
        check("rst_fault", Inst_Fault, 1'b0);
        check("rst_count", Fifo_Count, 3'd0);
      end
    end
    Load_En = 1'b0;
    Rst_n   = 1'b1;

    // First instruction valid after the first edge out of reset.
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
    check("first_valid", Inst_Valid, 1'b1);
    check("first_instruction", Instruction, 32'h1000_0000);
    stream(8, 1'b1);

    // Backpressure: FIFO saturates, then drains without gap or duplicate.
    stream(10, 1'b0);
    check("full_count", Fifo_Count, 3'd4);
    stream(8, 1'b1);

    // Redirect with unaligned target while partially full.
    stream(3, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 32'h23, 1'b0);
    check("redirect_flush", Fifo_Count, 3'd0);
    stream(6, 1'b1);

    // Run off the end of memory: two normal entries, then a fault and halt.
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 32'h3F8, 1'b1);
    stream(8, 1'b1);
    check("halt_empty", Inst_Valid, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 32'h0, 1'b1);
    stream(3, 1'b1);

    // Load during streaming, out-of-range load, then fetch the written word.
    cycle(1'b1, 32'h14, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 32'h400, 32'h1234_5678, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 32'h14, 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
    check("loaded_word", Instruction, 32'hDEAD_BEEF);
    stream(3, 1'b1);

    // Randomised traffic mixing loads, redirects and decoder stalls.
    seen_fault = 0;
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(3))
        0:       rnd_ra = $urandom;
        1:       rnd_ra = 32'h3E0 + $urandom_range(31);
        default: rnd_ra = $urandom_range(32'h3FF);
      endcase
      rnd_la = ($urandom_range(9) == 0) ? $urandom : $urandom_range(32'h3FF);
      cycle($urandom_range(9) == 0, rnd_la, $urandom,
            $urandom_range(99) < 6, rnd_ra, $urandom_range(9) < 7);
      if (Inst_Valid && Inst_Fault) seen_fault = 1;
    end
    check("random_fault_seen", seen_fault, 1'b1);

    // Asynchronous reset with a full FIFO; memory must survive.
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 32'h40, 1'b0);
    stream(6, 1'b0);
    #2;
    Rst_n = 1'b0;
    #1;
    check("async_rst_valid", Inst_Valid, 1'b0);
    check("async_rst_count", Fifo_Count, 3'd0);
    model_reset();
    @(posedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    stream(12, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
